// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the sample/response requesters, the arbiter and the UART transmitter.
// A word moves on a clock edge where valid & ready are both high; ready may depend combinationally on valid.
interface uart_tx_arb_if;
  logic        smp_valid;
  logic [31:0] smp_data;
  logic        smp_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        rsp_ready;
  logic        tx_write;
  logic [31:0] tx_wrdata;
  logic        tx_id;
  logic        tx_busy;

  modport slave (
    input  smp_valid, smp_data, rsp_valid, rsp_data, rsp_id, tx_busy,
    output smp_ready, rsp_ready, tx_write, tx_wrdata, tx_id
  );

  modport master (
    output smp_valid, smp_data, rsp_valid, rsp_data, rsp_id, tx_busy,
    input  smp_ready, rsp_ready, tx_write, tx_wrdata, tx_id
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Two-requester arbiter feeding one UART transmitter, with ack timeout and completed-word count.
// Define UART_TX_ARB_RR_EN for round-robin tie breaking; otherwise rsp has fixed priority over smp.
module uart_tx_arb #(
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_arb_if.slave     bus,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] xfer_count,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             tx_write_q, tx_write_d;
  logic             tx_id_q, tx_id_d;
  logic [31:0]      wrdata_q, wrdata_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
`ifdef UART_TX_ARB_RR_EN
  logic             last_rsp_q, last_rsp_d;
`endif

  logic pick_smp;
  logic pick_rsp;

  // Only offer ready while idle and the transmitter is free, so a handshake always starts a transfer.
  always_comb begin
    pick_smp = 1'b0;
    pick_rsp = 1'b0;
    if (state_q == IDLE && !bus.tx_busy) begin
`ifdef UART_TX_ARB_RR_EN
      if (bus.smp_valid && bus.rsp_valid) begin
        pick_rsp = !last_rsp_q;
        pick_smp = last_rsp_q;
      end else begin
        pick_smp = bus.smp_valid;
        pick_rsp = bus.rsp_valid;
      end
`else
      pick_rsp = bus.rsp_valid;
      pick_smp = bus.smp_valid && !bus.rsp_valid;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_write_d = 1'b0;
    tx_id_d    = 1'b0;
    wrdata_d   = wrdata_q;
    grant_d    = grant_q;
    count_d    = count_q;
    err_d      = err_q;
    ack_cnt_d  = ack_cnt_q;
`ifdef UART_TX_ARB_RR_EN
    last_rsp_d = last_rsp_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_smp) begin
          state_d    = ISSUE;
          tx_write_d = 1'b1;
          wrdata_d   = bus.smp_data;
          grant_d    = 2'b01;
        end else if (pick_rsp) begin
          state_d = ISSUE;
          grant_d = 2'b10;
          if (bus.rsp_id) begin
            tx_id_d  = 1'b1;
            wrdata_d = '0;
          end else begin
            tx_write_d = 1'b1;
            wrdata_d   = bus.rsp_data;
          end
        end
      end
      ISSUE: begin
        state_d   = WAIT_ACK;
        ack_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          grant_d = 2'b00;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
          grant_d = 2'b00;
          count_d = count_q + 1'b1;
`ifdef UART_TX_ARB_RR_EN
          last_rsp_d = grant_q[1];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_write_q <= 1'b0;
      tx_id_q    <= 1'b0;
      wrdata_q   <= '0;
      grant_q    <= 2'b00;
      count_q    <= '0;
      err_q      <= 1'b0;
      ack_cnt_q  <= '0;
`ifdef UART_TX_ARB_RR_EN
      last_rsp_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_write_q <= tx_write_d;
      tx_id_q    <= tx_id_d;
      wrdata_q   <= wrdata_d;
      grant_q    <= grant_d;
      count_q    <= count_d;
      err_q      <= err_d;
      ack_cnt_q  <= ack_cnt_d;
`ifdef UART_TX_ARB_RR_EN
      last_rsp_q <= last_rsp_d;
`endif
    end
  end

  assign bus.smp_ready = pick_smp;
  assign bus.rsp_ready = pick_rsp;
  assign bus.tx_write  = tx_write_q;
  assign bus.tx_id     = tx_id_q;
  assign bus.tx_wrdata = wrdata_q;
  assign grant         = grant_q;
  assign xfer_count    = count_q;
  assign err           = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: randomized requesters and a transmitter model, checked against a
// transfer-timeline reference model; directed lone/ID/tie/timeout/reset/wrap scenarios.
module tb_uart_tx_arb;
  localparam int ACK_TIMEOUT = 8;
  localparam int CNT_W       = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       grant;
  logic [CNT_W-1:0] xfer_count;
  logic             err;
  logic [1:0]       state_dbg;

  always #5 clock = ~clock;

  uart_tx_arb_if bus_if ();

  uart_tx_arb #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_if),
    .grant      (grant),
    .xfer_count (xfer_count),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  int vectors    = 0;
  int miscompares = 0;

  // reference model: one transfer at a time, described by cycles since its handshake
  bit               m_idle;
  int               m_t;
  int               m_len;      // busy pulse length in cycles; 0 = transmitter never acks
  bit               m_rsp;
  bit               m_isid;
  logic [31:0]      m_wr;
  logic [CNT_W-1:0] m_count;
  bit               m_err;
  bit               m_last_rsp;
  logic [33:0]      exp_q[$];   // {owner_is_rsp, is_id, wrdata}
  bit               owner_log[$];
  int               strobes_seen = 0;

  // stimulus controls
  bit          rand_mode = 1'b0;
  int          smp_left  = 0;
  int          rsp_left  = 0;
  logic [31:0] smp_fix   = '0;
  logic [31:0] rsp_fix   = '0;
  bit          rsp_id_fix = 1'b0;
  int          force_len = 3;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle     = 1'b1;
    m_t        = 0;
    m_len      = 0;
    m_rsp      = 1'b0;
    m_isid     = 1'b0;
    m_wr       = '0;
    m_count    = '0;
    m_err      = 1'b0;
    m_last_rsp = 1'b0;
    exp_q.delete();
  endtask

  task automatic step();
    logic [33:0] e;
    bit win_s, win_r;
    @(negedge clock);
    // a transfer ends one cycle after busy falls, or ACK_TIMEOUT+1 cycles after issue without ack
    if (!m_idle) begin
      m_t++;
      if (m_len > 0 && m_t == m_len + 1) begin
        m_idle     = 1'b1;
        m_count    = m_count + 1'b1;
        m_last_rsp = m_rsp;
      end else if (m_len == 0 && m_t == ACK_TIMEOUT + 1) begin
        m_idle = 1'b1;
        m_err  = 1'b1;
      end
    end
    check("tx_write", bus_if.tx_write, (!m_idle && m_t == 0 && !m_isid));
    check("tx_id", bus_if.tx_id, (!m_idle && m_t == 0 && m_isid));
    check("write_id_exclusive", bus_if.tx_write & bus_if.tx_id, 1'b0);
    if (bus_if.tx_write || bus_if.tx_id) begin
      strobes_seen++;
      owner_log.push_back(grant[1]);
      check("strobe_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("xfer_word", {grant[1], bus_if.tx_id, bus_if.tx_wrdata}, e);
      end
    end
    check("tx_wrdata", bus_if.tx_wrdata, m_wr);
    check("grant", grant, m_idle ? 2'b00 : (m_rsp ? 2'b10 : 2'b01));
    check("xfer_count", xfer_count, m_count);
    check("err", err, m_err);

    if (!m_idle) bus_if.tx_busy = (m_len > 0) && (m_t < m_len);
    else         bus_if.tx_busy = rand_mode && ($urandom_range(0, 7) == 0);

    if (rand_mode) begin
      bus_if.smp_valid = ($urandom_range(0, 1) == 1);
      bus_if.smp_data  = $urandom;
      bus_if.rsp_valid = ($urandom_range(0, 2) == 0);
      bus_if.rsp_data  = $urandom;
      bus_if.rsp_id    = ($urandom_range(0, 3) == 0);
    end else begin
      bus_if.smp_valid = (smp_left > 0) && !reset;
      bus_if.smp_data  = smp_fix;
      bus_if.rsp_valid = (rsp_left > 0) && !reset;
      bus_if.rsp_data  = rsp_fix;
      bus_if.rsp_id    = rsp_id_fix;
    end
    #1;
    win_s = 1'b0;
    win_r = 1'b0;
    if (m_idle && !bus_if.tx_busy && !reset) begin
      if (bus_if.smp_valid && bus_if.rsp_valid) begin
`ifdef UART_TX_ARB_RR_EN
        if (m_last_rsp) win_s = 1'b1;
        else            win_r = 1'b1;
`else
        win_r = 1'b1;
`endif
      end else begin
        win_s = bus_if.smp_valid;
        win_r = bus_if.rsp_valid;
      end
    end
    check("smp_ready", bus_if.smp_ready, win_s);
    check("rsp_ready", bus_if.rsp_ready, win_r);
    if (win_s || win_r) begin
      m_idle = 1'b0;
      m_t    = -1;
      m_rsp  = win_r;
      m_isid = win_r && bus_if.rsp_id;
      m_wr   = m_isid ? 32'h0 : (win_r ? bus_if.rsp_data : bus_if.smp_data);
      exp_q.push_back({m_rsp, m_isid, m_wr});
      if (force_len >= 0) m_len = force_len;
      else m_len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 6);
      if (!rand_mode) begin
        if (win_s) smp_left--;
        else       rsp_left--;
      end
    end
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((smp_left > 0 || rsp_left > 0 || !m_idle) && n < budget) begin
      step();
      n++;
    end
    check("done_within_budget", (n < budget), 1'b1);
  endtask

  initial begin
    int base, n;
    logic [CNT_W-1:0] cnt_save, cnt_exp;
    bit tie_exp [4];
    bus_if.smp_valid = 1'b0;
    bus_if.smp_data  = '0;
    bus_if.rsp_valid = 1'b0;
    bus_if.rsp_data  = '0;
    bus_if.rsp_id    = 1'b0;
    bus_if.tx_busy   = 1'b0;
    model_reset();

    // reset state
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // lone sample word, long busy
    base = strobes_seen;
    smp_fix = 32'h1234_5678; force_len = 40; smp_left = 1;
    run_until_done(80);
    check("lone_strobes", strobes_seen - base, 1);
    check("lone_count", xfer_count, 1);

    // tie: both requesters continuously valid for 4 words
    owner_log.delete();
    base = strobes_seen;
    smp_fix = 32'hA5A5_0001; rsp_fix = 32'h5A5A_0002; rsp_id_fix = 1'b0; force_len = 3;
    smp_left = 4; rsp_left = 4;
    n = 0;
    while (strobes_seen - base < 4 && n < 100) begin
      step();
      n++;
    end
    smp_left = 0; rsp_left = 0;
    run_until_done(40);
`ifdef UART_TX_ARB_RR_EN
    tie_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    tie_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    check("tie_words", owner_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < owner_log.size()) check($sformatf("tie_owner%0d", i), owner_log[i], tie_exp[i]);
    end

    // ID request: data must be ignored
    owner_log.delete();
    rsp_fix = 32'hDEAD_BEEF; rsp_id_fix = 1'b1; force_len = 4; rsp_left = 1;
    run_until_done(40);
    check("id_strobes", owner_log.size(), 1);
    rsp_id_fix = 1'b0;

    // ack timeout
    cnt_save = m_count;
    smp_fix = 32'h0BAD_0ACC; force_len = 0; smp_left = 1;
    run_until_done(40);
    check("timeout_err", err, 1'b1);
    check("timeout_count", xfer_count, cnt_save);
    repeat (20) step();
    check("err_sticky", err, 1'b1);
    force_len = 3; smp_left = 1;
    run_until_done(40);
    cnt_exp = cnt_save + 1'b1;
    check("served_after_timeout", xfer_count, cnt_exp);

    // randomized traffic
    rand_mode = 1'b1; force_len = -1;
    repeat (400) step();
    rand_mode = 1'b0; force_len = 3;
    run_until_done(60);

    // reset while the transmitter is busy
    smp_fix = $urandom; force_len = 20; smp_left = 1;
    n = 0;
    while (!(!m_idle && m_t == 5) && n < 60) begin
      step();
      n++;
    end
    check("reached_wait_done", (!m_idle && m_t == 5), 1'b1);
    reset = 1'b1;
    #1;
    check("rst_tx_write", bus_if.tx_write, 1'b0);
    check("rst_tx_id", bus_if.tx_id, 1'b0);
    check("rst_tx_wrdata", bus_if.tx_wrdata, 32'h0);
    check("rst_grant", grant, 2'b00);
    check("rst_xfer_count", xfer_count, 0);
    check("rst_err", err, 1'b0);
    model_reset();
    smp_left = 0;
    repeat (2) step();
    reset = 1'b0;
    base = strobes_seen;
    repeat (30) step();
    check("no_strobe_after_reset", strobes_seen - base, 0);

    // counter wrap: 17 transfers on a 4-bit counter
    force_len = 2; smp_fix = 32'h0000_0017; smp_left = 17;
    run_until_done(17 * 6 + 20);
    check("wrap_count", xfer_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
